// File: rtl/mac_dot_sat_if.sv
// mac_dot_sat_if: operand/result bundle for the saturating dot-product MAC.
//   master : drives a, b, valid_in; observes f, valid_out, overflow
//   slave  : the MAC itself; consumes operands, produces results
//   a, b       signed operands, sampled when valid_in=1
//   valid_in   operand pair valid (no backpressure)
//   f          signed saturated dot-product result, held until next result
//   valid_out  one-cycle pulse marking a new result on f
//   overflow   sticky saturation flag for the group reported on f
interface mac_dot_sat_if #(
    parameter int WIDTH_IN  = 12,
    parameter int WIDTH_OUT = 24
);
    logic signed [WIDTH_IN-1:0]  a;
    logic signed [WIDTH_IN-1:0]  b;
    logic                        valid_in;
    logic signed [WIDTH_OUT-1:0] f;
    logic                        valid_out;
    logic                        overflow;

    modport master (output a, output b, output valid_in,
                    input  f, input  valid_out, input  overflow);
    modport slave  (input  a, input  b, input  valid_in,
                    output f, output valid_out, output overflow);
endinterface

// File: rtl/mac_dot_sat.sv
// mac_dot_sat: signed dot product of N_TERMS (a, b) pairs with saturating,
// saturate-and-continue accumulation and a per-group sticky overflow flag.
// The accumulator auto-clears at each group boundary, so groups may run
// back-to-back without a bubble.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (clears all state and outputs)
//   bus    mac_dot_sat_if.slave: a, b, valid_in in; f, valid_out, overflow out
// Build option:
//   MAC_DOT_PIPE_MULT_EN  adds a product register between the input stage and
//                         the accumulator (latency 3 instead of 2); results,
//                         overflow and throughput are unchanged.
module mac_dot_sat #(
    parameter int WIDTH_IN  = 12,
    parameter int WIDTH_OUT = 24,
    parameter int N_TERMS   = 4
) (
    input  logic          clk,
    input  logic          reset,
    mac_dot_sat_if.slave  bus
);
    localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam int PW = 2 * WIDTH_IN;
    localparam logic [CW-1:0] LAST_TERM = CW'(N_TERMS - 1);
    localparam logic signed [WIDTH_OUT-1:0] ACC_MAX = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    localparam logic signed [WIDTH_OUT-1:0] ACC_MIN = {1'b1, {(WIDTH_OUT-1){1'b0}}};

    logic signed [WIDTH_IN-1:0]  a_r;
    logic signed [WIDTH_IN-1:0]  b_r;
    logic                        v1_r;
    logic signed [PW-1:0]        prod_s;
    logic signed [PW-1:0]        term_p_s;
    logic                        term_v_s;
    logic signed [WIDTH_OUT:0]   p_ext_s;
    logic signed [WIDTH_OUT:0]   base_s;
    logic signed [WIDTH_OUT:0]   sum_s;
    logic signed [WIDTH_OUT-1:0] res_s;
    logic                        sat_s;
    logic                        first_s;
    logic                        last_s;
    logic                        ovf_next_s;
    logic signed [WIDTH_OUT-1:0] acc_r;
    logic [CW-1:0]               cnt_r;
    logic                        ovf_r;
    logic signed [WIDTH_OUT-1:0] f_r;
    logic                        valid_out_r;
    logic                        overflow_r;

    // Input register stage: captures operands every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r  <= {WIDTH_IN{1'b0}};
            b_r  <= {WIDTH_IN{1'b0}};
            v1_r <= 1'b0;
        end else begin
            a_r  <= bus.a;
            b_r  <= bus.b;
            v1_r <= bus.valid_in;
        end
    end

    // Operands are sign-extended to the product width so the multiply is
    // exact regardless of how the tool sizes the expression.
    assign prod_s = $signed({{WIDTH_IN{a_r[WIDTH_IN-1]}}, a_r})
                  * $signed({{WIDTH_IN{b_r[WIDTH_IN-1]}}, b_r});

`ifdef MAC_DOT_PIPE_MULT_EN
    logic signed [PW-1:0] p_r;
    logic                 v2_r;

    // Product register stage: splits multiply from the accumulate add.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_r  <= {PW{1'b0}};
            v2_r <= 1'b0;
        end else begin
            p_r  <= prod_s;
            v2_r <= v1_r;
        end
    end

    assign term_p_s = p_r;
    assign term_v_s = v2_r;
`else
    assign term_p_s = prod_s;
    assign term_v_s = v1_r;
`endif

    assign first_s = (cnt_r == {CW{1'b0}});
    assign last_s  = (cnt_r == LAST_TERM);

    // One guard bit above the accumulator: acc + product can never wrap there,
    // so the top two bits differing means the sum left the representable range.
    assign p_ext_s = {{(WIDTH_OUT+1-PW){term_p_s[PW-1]}}, term_p_s};
    assign base_s  = first_s ? {(WIDTH_OUT+1){1'b0}} : {acc_r[WIDTH_OUT-1], acc_r};
    assign sum_s   = base_s + p_ext_s;

    // Saturation clamp of the guarded sum.
    always_comb begin
        res_s = sum_s[WIDTH_OUT-1:0];
        sat_s = 1'b0;
        if (sum_s[WIDTH_OUT] != sum_s[WIDTH_OUT-1]) begin
            sat_s = 1'b1;
            if (sum_s[WIDTH_OUT]) begin
                res_s = ACC_MIN;
            end else begin
                res_s = ACC_MAX;
            end
        end else begin
            res_s = sum_s[WIDTH_OUT-1:0];
            sat_s = 1'b0;
        end
    end

    // The sticky flag from a previous group is dropped on its first term.
    assign ovf_next_s = sat_s | (ovf_r & ~first_s);

    // Accumulate stage: running sum, term counter, sticky flag and result regs.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r       <= {WIDTH_OUT{1'b0}};
            cnt_r       <= {CW{1'b0}};
            ovf_r       <= 1'b0;
            f_r         <= {WIDTH_OUT{1'b0}};
            valid_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            valid_out_r <= term_v_s & last_s;
            if (term_v_s) begin
                acc_r <= res_s;
                ovf_r <= ovf_next_s;
                if (last_s) begin
                    cnt_r      <= {CW{1'b0}};
                    f_r        <= res_s;
                    overflow_r <= ovf_next_s;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end
        end
    end

    assign bus.f         = f_r;
    assign bus.valid_out = valid_out_r;
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_mac_dot_sat.sv
// tb_mac_dot_sat: randomized and directed self-checking bench for mac_dot_sat.
// A group-level reference model computes each dot product from the collected
// pairs with plain integer arithmetic and schedules the expected result pulse.
module tb_mac_dot_sat;
    localparam int WI = 12;
    localparam int WO = 24;
    localparam int NT = 4;
`ifdef MAC_DOT_PIPE_MULT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam longint RMAX = (64'sd1 <<< (WO - 1)) - 64'sd1;
    localparam longint RMIN = -(64'sd1 <<< (WO - 1));

    typedef struct {
        int     cyc;
        longint f;
        longint ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t   exp_q[$];
    longint grp_a[$];
    longint grp_b[$];
    longint held_f = 0;
    longint held_ovf = 0;

    always #5 clk = ~clk;

    mac_dot_sat_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) bus ();

    mac_dot_sat #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .N_TERMS(NT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input longint obs, input longint expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Reference: dot product of one full group, clamp after every term.
    task automatic model_push(input longint av, input longint bv, input int c);
        longint acc;
        longint ovf;
        grp_a.push_back(av);
        grp_b.push_back(bv);
        if (grp_a.size() == NT) begin
            acc = 0;
            ovf = 0;
            for (int i = 0; i < NT; i++) begin
                acc = acc + grp_a[i] * grp_b[i];
                if (acc > RMAX) begin
                    acc = RMAX;
                    ovf = 1;
                end else if (acc < RMIN) begin
                    acc = RMIN;
                    ovf = 1;
                end
            end
            exp_q.push_back('{c + LAT, acc, ovf});
            grp_a.delete();
            grp_b.delete();
        end
    endtask

    // Called at a negedge; leaves the bench at a negedge after the gap.
    task automatic send_pair(input int av, input int bv, input int gap);
        logic [31:0] ua;
        logic [31:0] ub;
        ua = av;
        ub = bv;
        bus.a        = ua[WI-1:0];
        bus.b        = ub[WI-1:0];
        bus.valid_in = 1'b1;
        model_push(longint'(av), longint'(bv), cyc);
        @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        grp_a.delete();
        grp_b.delete();
        exp_q.delete();
        held_f   = 0;
        held_ovf = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: compares every cycle shortly after the active edge.
    always @(posedge clk) begin
        bit exp_v;
        cyc++;
        #2;
        if (!reset) begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check("valid_out", longint'(bus.valid_out), longint'(exp_v));
            if (exp_v) begin
                check("f", longint'(bus.f), exp_q[0].f);
                check("overflow", longint'(bus.overflow), exp_q[0].ovf);
                held_f   = exp_q[0].f;
                held_ovf = exp_q[0].ovf;
                void'(exp_q.pop_front());
            end else begin
                check("f_hold", longint'(bus.f), held_f);
                check("ovf_hold", longint'(bus.overflow), held_ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int av;
        int bv;
        int gap;
        reset        = 1'b1;
        bus.a        = '0;
        bus.b        = '0;
        bus.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        check("rst_f", longint'(bus.f), 0);
        check("rst_valid_out", longint'(bus.valid_out), 0);
        check("rst_overflow", longint'(bus.overflow), 0);

        // Back-to-back group.
        send_pair(1, 2, 0); send_pair(3, 4, 0); send_pair(5, 6, 0); send_pair(7, 8, 0);
        drain();
        check("s1_f", longint'(bus.f), 100);
        check("s1_ovf", longint'(bus.overflow), 0);

        // Same group with idle gaps; result must hold afterwards.
        send_pair(1, 2, 1); send_pair(3, 4, 3); send_pair(5, 6, 2); send_pair(7, 8, 1);
        drain();
        repeat (5) @(negedge clk);
        check("s2_f_hold", longint'(bus.f), 100);

        // Positive clamp, then auto-clear.
        for (int i = 0; i < 4; i++) send_pair(-2048, -2048, 0);
        for (int i = 0; i < 4; i++) send_pair(1, 1, 0);
        repeat (LAT) @(negedge clk);
        drain();
        check("s3_f", longint'(bus.f), 4);
        check("s3_ovf", longint'(bus.overflow), 0);

        // Negative clamp.
        for (int i = 0; i < 4; i++) send_pair(-2048, 2047, 0);
        drain();
        check("s4_f_min", longint'(bus.f), -8388608);
        check("s4_ovf", longint'(bus.overflow), 1);
        send_pair(-2048, -2048, 0);
        for (int i = 0; i < 3; i++) send_pair(-2048, 2047, 0);
        drain();
        check("s4_f_recover", longint'(bus.f), -8382464);

        // Reset mid-group discards the partial sum.
        send_pair(100, 100, 0);
        send_pair(100, 100, 0);
        do_reset();
        check("s5_f_after_rst", longint'(bus.f), 0);
        for (int i = 0; i < 4; i++) send_pair(1, 1, 0);
        drain();
        check("s5_f", longint'(bus.f), 4);
        check("s5_ovf", longint'(bus.overflow), 0);

        // Continuous 8-pair stream.
        for (int i = 0; i < 8; i++) send_pair(i + 1, i - 3, 0);
        drain();

        // Randomized stream with extremes and occasional gaps.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) av = ($urandom_range(0, 1) == 0) ? -2048 : 2047;
            else av = int'($urandom_range(0, 4095)) - 2048;
            if ($urandom_range(0, 3) == 0) bv = ($urandom_range(0, 1) == 0) ? -2048 : 2047;
            else bv = int'($urandom_range(0, 4095)) - 2048;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_pair(av, bv, gap);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
